// File: rtl/udp_tx.sv
// udp_tx: builds and serialises a complete Ethernet/IPv4/UDP frame onto an RMII
// transmit interface (2 bits per 50 MHz clock, 4 clocks per byte).
//
// Frame: preamble + SFD, Ethernet header, IPv4 header (checksum generated),
// UDP header (checksum 0), payload pulled from a byte source, optional pad, CRC-32 FCS,
// followed by an inter-frame gap.
//
// Configuration macro: UDP_TX_PAD_EN -- when defined, frames with fewer than 18 payload
// bytes are zero-padded up to the 64-byte Ethernet minimum. When undefined, no PAD state
// exists and runt frames are sent as-is.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              frame request, sampled only while idle
//   busy               high from the cycle after an accepted start through the done cycle
//   done               one-cycle pulse on the last inter-frame-gap cycle
//   macLoc, macRem     source / destination MAC
//   ipLoc, ipRem       source / destination IPv4 address
//   ipID               IPv4 identification
//   portLoc, portRem   UDP source / destination port
//   lenPayload         UDP payload length in bytes (clamped to 1472)
//   dataIn, dataRd     payload source; dataIn is consumed on the edge where dataRd is high
//   PhyTxd, PhyTxEn    RMII transmit dibit and enable
`timescale 1ns/1ps
module udp_tx #(
  parameter logic [7:0]  TTL       = 8'h80,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [47:0] macLoc,
  input  logic [47:0] macRem,
  input  logic [31:0] ipLoc,
  input  logic [31:0] ipRem,
  input  logic [15:0] ipID,
  input  logic [15:0] portLoc,
  input  logic [15:0] portRem,
  input  logic [15:0] lenPayload,
  input  logic [7:0]  dataIn,
  output logic        dataRd,
  output logic [1:0]  PhyTxd,
  output logic        PhyTxEn
);

  localparam logic [15:0] MaxPayload = 16'd1472;
  localparam logic [15:0] IfgLast    = 16'(IFG_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StHeader,
    StPayload,
`ifdef UDP_TX_PAD_EN
    StPad,
`endif
    StFcs,
    StIfg
  } state_e;

  state_e      state_q, state_d;
  state_e      after_pay_st;
  logic [1:0]  dibit_q, dibit_d;
  logic [15:0] byte_q, byte_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  data_q;

  logic [47:0] mac_loc_q, mac_rem_q;
  logic [31:0] ip_loc_q, ip_rem_q;
  logic [15:0] ip_id_q, port_loc_q, port_rem_q;
  logic [10:0] len_q;

  logic        accept;
  logic        byte_end;
  logic        byte_last;
  logic        data_rd;
  logic [15:0] last_idx;
  logic [7:0]  cur_byte;
  logic [7:0]  hdr_byte;
  logic [7:0]  fcs_byte;
  logic [15:0] ip_len, udp_len, ip_csum;
  logic [31:0] csum_acc, csum_fold1, csum_fold2;
  logic [335:0] hdr, hdr_shifted;
  logic [8:0]  hdr_sel;
  logic [31:0] fcs;

  // Reflected CRC-32, one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign accept = (state_q == StIdle) && start;

  // Everything describing the frame is frozen at the accepting edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mac_loc_q  <= '0;
      mac_rem_q  <= '0;
      ip_loc_q   <= '0;
      ip_rem_q   <= '0;
      ip_id_q    <= '0;
      port_loc_q <= '0;
      port_rem_q <= '0;
      len_q      <= '0;
    end else if (accept) begin
      mac_loc_q  <= macLoc;
      mac_rem_q  <= macRem;
      ip_loc_q   <= ipLoc;
      ip_rem_q   <= ipRem;
      ip_id_q    <= ipID;
      port_loc_q <= portLoc;
      port_rem_q <= portRem;
      len_q      <= (lenPayload > MaxPayload) ? MaxPayload[10:0] : lenPayload[10:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (data_rd) begin
      data_q <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      dibit_q <= '0;
      byte_q  <= '0;
      crc_q   <= '0;
    end else begin
      state_q <= state_d;
      dibit_q <= dibit_d;
      byte_q  <= byte_d;
      crc_q   <= crc_d;
    end
  end

  // Length fields and IPv4 header checksum (checksum field taken as zero).
  assign ip_len  = 16'(len_q) + 16'd28;
  assign udp_len = 16'(len_q) + 16'd8;

  always_comb begin
    csum_acc = 32'h0000_4500 + 32'(ip_len) + 32'(ip_id_q) + 32'({TTL, 8'h11})
             + 32'(ip_loc_q[31:16]) + 32'(ip_loc_q[15:0])
             + 32'(ip_rem_q[31:16]) + 32'(ip_rem_q[15:0]);
    // Two folds are enough: the first leaves at most a 17-bit value.
    csum_fold1 = 32'(csum_acc[15:0]) + 32'(csum_acc[31:16]);
    csum_fold2 = 32'(csum_fold1[15:0]) + 32'(csum_fold1[31:16]);
    ip_csum    = ~csum_fold2[15:0];
  end

  // 42 header bytes, first-transmitted byte in the top bits.
  assign hdr = {mac_rem_q, mac_loc_q, 16'h0800,
                16'h4500, ip_len, ip_id_q, 16'h0000, TTL, 8'h11, ip_csum, ip_loc_q, ip_rem_q,
                port_loc_q, port_rem_q, udp_len, 16'h0000};

  assign hdr_sel     = {6'd41 - byte_q[5:0], 3'b000};
  assign hdr_shifted = hdr >> hdr_sel;
  assign hdr_byte    = hdr_shifted[7:0];

  // FCS goes out least significant byte first.
  assign fcs = ~crc_q;
  always_comb begin
    case (byte_q[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

`ifdef UDP_TX_PAD_EN
  logic [4:0] pad_len;
  assign pad_len      = (len_q < 11'd18) ? 5'(11'd18 - len_q) : 5'd0;
  assign after_pay_st = (pad_len != 5'd0) ? StPad : StFcs;
`else
  assign after_pay_st = StFcs;
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      StPreamble: cur_byte = (byte_q == 16'd7) ? 8'hD5 : 8'h55;
      StHeader:   cur_byte = hdr_byte;
      StPayload:  cur_byte = data_q;
      StFcs:      cur_byte = fcs_byte;
      default:    cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    last_idx = 16'd0;
    case (state_q)
      StPreamble: last_idx = 16'd7;
      StHeader:   last_idx = 16'd41;
      StPayload:  last_idx = 16'(len_q) - 16'd1;
`ifdef UDP_TX_PAD_EN
      StPad:      last_idx = 16'(pad_len) - 16'd1;
`endif
      StFcs:      last_idx = 16'd3;
      StIfg:      last_idx = IfgLast;
      default:    last_idx = 16'd0;
    endcase
  end

  assign byte_end  = (dibit_q == 2'd3);
  assign byte_last = byte_end && (byte_q == last_idx);

  // Next state, counters, CRC and handshake strobes.
  always_comb begin
    state_d = state_q;
    dibit_d = dibit_q + 2'd1;
    byte_d  = byte_end ? (byte_q + 16'd1) : byte_q;
    crc_d   = crc_q;
    data_rd = 1'b0;
    done    = 1'b0;

    case (state_q)
      StIdle: begin
        dibit_d = 2'd0;
        byte_d  = 16'd0;
        if (start) begin
          state_d = StPreamble;
          crc_d   = 32'hFFFF_FFFF;
        end
      end
      StPreamble: begin
        if (byte_last) state_d = StHeader;
      end
      StHeader: begin
        // Fetch the first payload byte during the final header byte.
        data_rd = byte_last && (len_q != 11'd0);
        if (byte_last) state_d = (len_q != 11'd0) ? StPayload : after_pay_st;
      end
      StPayload: begin
        data_rd = byte_end && !byte_last;
        if (byte_last) state_d = after_pay_st;
      end
`ifdef UDP_TX_PAD_EN
      StPad: begin
        if (byte_last) state_d = StFcs;
      end
`endif
      StFcs: begin
        if (byte_last) state_d = StIfg;
      end
      StIfg: begin
        done = byte_last;
        if (byte_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (byte_last) byte_d = 16'd0;

    // CRC covers destination MAC through the last payload/pad byte.
    if (byte_end && (state_q == StHeader || state_q == StPayload
`ifdef UDP_TX_PAD_EN
        || state_q == StPad
`endif
        )) begin
      crc_d = crc32_byte(crc_q, cur_byte);
    end
  end

  assign busy    = (state_q != StIdle);
  assign dataRd  = data_rd;
  assign PhyTxEn = (state_q != StIdle) && (state_q != StIfg);

  always_comb begin
    PhyTxd = 2'b00;
    if (PhyTxEn) begin
      case (dibit_q)
        2'd0:    PhyTxd = cur_byte[1:0];
        2'd1:    PhyTxd = cur_byte[3:2];
        2'd2:    PhyTxd = cur_byte[5:4];
        default: PhyTxd = cur_byte[7:6];
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx.sv
`timescale 1ns/1ps
module tb_udp_tx;

  localparam int IFG   = 12;
  localparam int BOUND = 7000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, dataRd, PhyTxEn;
  logic [1:0]  PhyTxd;
  logic [47:0] macLoc, macRem;
  logic [31:0] ipLoc, ipRem;
  logic [15:0] ipID, portLoc, portRem, lenPayload;
  logic [7:0]  dataIn;

  always #10 clk = ~clk;

  udp_tx #(
    .TTL       (8'h80),
    .IFG_BYTES (IFG)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .macLoc     (macLoc),
    .macRem     (macRem),
    .ipLoc      (ipLoc),
    .ipRem      (ipRem),
    .ipID       (ipID),
    .portLoc    (portLoc),
    .portRem    (portRem),
    .lenPayload (lenPayload),
    .dataIn     (dataIn),
    .dataRd     (dataRd),
    .PhyTxd     (PhyTxd),
    .PhyTxEn    (PhyTxEn)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Payload source: a random byte stream that advances once per consumed byte.
  logic [7:0] pay_mem [2048];
  int         rd_idx = 0;
  bit         rd_pend = 1'b0;
  always @(negedge clk) begin
    if (rd_pend) rd_idx <= rd_idx + 1;
    rd_pend <= dataRd;
  end
  assign dataIn = pay_mem[rd_idx[10:0]];

  // Model copies of the frame inputs at start time.
  logic [47:0] m_mac_loc, m_mac_rem;
  logic [31:0] m_ip_loc, m_ip_rem;
  logic [15:0] m_ip_id, m_port_loc, m_port_rem;
  int          m_len, m_base, exp_txen;
  logic [7:0]  exp_q[$];

  // Observations of one frame.
  logic [1:0]  obs_d[$];
  logic [7:0]  obs_b[$];
  int          rd_cyc[$];
  int          txen_cnt, last_txen, done_cyc;
  bit          done_busy, first_txen, first_busy;
  logic [1:0]  first_txd;

  function automatic int pad_of(input int len);
`ifdef UDP_TX_PAD_EN
    return (len < 18) ? 18 - len : 0;
`else
    return 0;
`endif
  endfunction

  // Bit-serial reflected CRC-32, init all ones, no final inversion.
  function automatic logic [31:0] crc_run(input logic [7:0] q[$], input int from);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = from; i < q.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        logic fb = c[0] ^ q[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic rand_inputs();
    macLoc     = 48'({$urandom(), $urandom()});
    macRem     = 48'({$urandom(), $urandom()});
    ipLoc      = $urandom();
    ipRem      = $urandom();
    ipID       = 16'($urandom());
    portLoc    = 16'($urandom());
    portRem    = 16'($urandom());
    lenPayload = 16'($urandom());
  endtask

  task automatic save_model();
    m_mac_loc  = macLoc;
    m_mac_rem  = macRem;
    m_ip_loc   = ipLoc;
    m_ip_rem   = ipRem;
    m_ip_id    = ipID;
    m_port_loc = portLoc;
    m_port_rem = portRem;
    m_len      = (lenPayload > 16'd1472) ? 1472 : int'(lenPayload);
    m_base     = rd_idx;
  endtask

  task automatic build_exp();
    int s;
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_be(m_mac_rem, 6);
    push_be(m_mac_loc, 6);
    push_be(48'h0800, 2);
    push_be(48'h4500, 2);
    push_be(48'(m_len + 28), 2);
    push_be(48'(m_ip_id), 2);
    push_be(48'h0, 2);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h11);
    s = 'h4500 + m_len + 28 + int'(m_ip_id) + 'h8011 + int'(m_ip_loc[31:16])
      + int'(m_ip_loc[15:0]) + int'(m_ip_rem[31:16]) + int'(m_ip_rem[15:0]);
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    push_be(48'((~s) & 'hFFFF), 2);
    push_be(48'(m_ip_loc), 4);
    push_be(48'(m_ip_rem), 4);
    push_be(48'(m_port_loc), 2);
    push_be(48'(m_port_rem), 2);
    push_be(48'(m_len + 8), 2);
    push_be(48'h0, 2);
    for (int i = 0; i < m_len; i++) exp_q.push_back(pay_mem[(m_base + i) % 2048]);
    for (int i = 0; i < pad_of(m_len); i++) exp_q.push_back(8'h00);
    c = ~crc_run(exp_q, 8);
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    exp_txen = 4 * (54 + m_len + pad_of(m_len));
  endtask

  // Request a frame; returns at the negedge of the first transmit cycle.
  task automatic kick(input int len, input bit fixed);
    @(negedge clk);
    rand_inputs();
    if (fixed) begin
      ipLoc = 32'hC0A80001;
      ipRem = 32'hC0A80002;
      ipID  = 16'h0001;
    end
    lenPayload = 16'(len);
    save_model();
    build_exp();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_txen = PhyTxEn;
    first_txd  = PhyTxd;
    first_busy = busy;
    rand_inputs();  // must not affect the frame in flight
  endtask

  // Record the frame from the current negedge until done (or the bound expires).
  task automatic collect(output bit ok);
    obs_d.delete();
    obs_b.delete();
    rd_cyc.delete();
    txen_cnt = 0;
    last_txen = -1;
    done_cyc = -1;
    done_busy = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < BOUND; c++) begin
      if (PhyTxEn) begin
        obs_d.push_back(PhyTxd);
        txen_cnt++;
        last_txen = c;
      end
      if (dataRd) rd_cyc.push_back(c);
      if (done) begin
        done_cyc = c;
        done_busy = busy;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    for (int i = 0; i + 3 < obs_d.size(); i += 4)
      obs_b.push_back({obs_d[i+3], obs_d[i+2], obs_d[i+1], obs_d[i]});
  endtask

  function automatic int byte_diffs();
    int n = 0;
    int lim = (obs_b.size() < exp_q.size()) ? obs_b.size() : exp_q.size();
    if (obs_b.size() != exp_q.size()) n++;
    for (int i = 0; i < lim; i++) if (obs_b[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    start = 1'b1;
    #5;
    tests_run++;
    if ({busy, done, dataRd, PhyTxEn, PhyTxd} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 000000", {busy, done, dataRd, PhyTxEn, PhyTxd});
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_start_ignored: busy got %b expected 0", busy);
    end
    start = 1'b0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_checksum();
    bit ok;
    kick(18, 1'b1);
    collect(ok);
    tests_run++;
    if ({first_txen, first_busy, first_txd} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL first_cycle: got en/busy/txd %b expected 1101", {first_txen, first_busy, first_txd});
    end
    tests_run++;
    if (!ok || txen_cnt != 288) begin
      tests_failed++;
      $display("FAIL cksum_txen: got %0d (done=%0d) expected 288", txen_cnt, ok);
    end
    tests_run++;
    if (obs_b.size() < 48 || {obs_b[24], obs_b[25]} !== 16'h002E
        || {obs_b[46], obs_b[47]} !== 16'h001A || {obs_b[32], obs_b[33]} !== 16'hB96A) begin
      tests_failed++;
      $display("FAIL cksum_fields: got %0d bytes, iplen %h udplen %h csum %h expected 002e 001a b96a",
               obs_b.size(), obs_b.size() > 47 ? {obs_b[24], obs_b[25]} : 16'h0,
               obs_b.size() > 47 ? {obs_b[46], obs_b[47]} : 16'h0,
               obs_b.size() > 47 ? {obs_b[32], obs_b[33]} : 16'h0);
    end
    tests_run++;
    if (byte_diffs() != 0) begin
      tests_failed++;
      $display("FAIL cksum_frame: got %0d byte differences expected 0", byte_diffs());
    end
  endtask

  task automatic test_fcs();
    bit ok;
    for (int k = 0; k < 3; k++) begin
      kick(int'($urandom_range(0, 64)), 1'b0);
      collect(ok);
      tests_run++;
      if (!ok || crc_run(obs_b, 8) !== 32'hDEBB20E3) begin
        tests_failed++;
        $display("FAIL fcs_residue: got %h expected debb20e3", crc_run(obs_b, 8));
      end
      tests_run++;
      if (txen_cnt != exp_txen || byte_diffs() != 0) begin
        tests_failed++;
        $display("FAIL fcs_frame: got txen %0d diffs %0d expected txen %0d diffs 0",
                 txen_cnt, byte_diffs(), exp_txen);
      end
    end
  endtask

  task automatic test_padding();
    bit ok;
    int want;
`ifdef UDP_TX_PAD_EN
    want = 288;
`else
    want = 216;
`endif
    kick(0, 1'b0);
    collect(ok);
    tests_run++;
    if (!ok || txen_cnt != want) begin
      tests_failed++;
      $display("FAIL pad_txen: got %0d expected %0d", txen_cnt, want);
    end
    tests_run++;
    if (rd_cyc.size() != 0) begin
      tests_failed++;
      $display("FAIL pad_no_read: got %0d dataRd pulses expected 0", rd_cyc.size());
    end
    tests_run++;
    if (byte_diffs() != 0) begin
      tests_failed++;
      $display("FAIL pad_frame: got %0d byte differences expected 0", byte_diffs());
    end
  endtask

  task automatic test_handshake();
    bit ok;
    int bad = 0;
    kick(1472, 1'b0);
    collect(ok);
    for (int i = 1; i < rd_cyc.size(); i++) if (rd_cyc[i] - rd_cyc[i-1] != 4) bad++;
    tests_run++;
    if (rd_cyc.size() != 1472 || bad != 0 || rd_cyc[0] != 199) begin
      tests_failed++;
      $display("FAIL rd_pulses: got %0d pulses, %0d bad gaps, first at %0d expected 1472, 0, 199",
               rd_cyc.size(), bad, rd_cyc.size() > 0 ? rd_cyc[0] : -1);
    end
    tests_run++;
    if (!ok || byte_diffs() != 0 || txen_cnt != 4 * (54 + 1472)) begin
      tests_failed++;
      $display("FAIL big_frame: got diffs %0d txen %0d expected 0 and %0d",
               byte_diffs(), txen_cnt, 4 * (54 + 1472));
    end
    tests_run++;
    if (done_cyc - last_txen != 4 * IFG || !done_busy) begin
      tests_failed++;
      $display("FAIL done_timing: got %0d cycles (busy %b) expected %0d (busy 1)",
               done_cyc - last_txen, done_busy, 4 * IFG);
    end
    @(negedge clk);
    tests_run++;
    if ({done, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL done_pulse: got done/busy %b expected 00", {done, busy});
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      kick(int'($urandom_range(0, 1600)), 1'b0);
      collect(ok);
      tests_run++;
      if (!ok || byte_diffs() != 0 || txen_cnt != exp_txen || rd_cyc.size() != m_len) begin
        tests_failed++;
        $display("FAIL random_frame: got diffs %0d txen %0d reads %0d expected 0, %0d, %0d",
                 byte_diffs(), txen_cnt, rd_cyc.size(), exp_txen, m_len);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    kick(200, 1'b0);
    for (int c = 0; c < 3000 && n < 10; c++) begin
      @(negedge clk);
      if (dataRd) n++;
    end
    #3 rstn = 1'b0;
    #1;
    tests_run++;
    if (n != 10 || {PhyTxEn, PhyTxd, busy, dataRd} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got reads %0d en/txd/busy/rd %b expected 10, 00000",
               n, {PhyTxEn, PhyTxd, busy, dataRd});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    kick(int'($urandom_range(0, 100)), 1'b0);
    collect(ok);
    tests_run++;
    if (!ok || byte_diffs() != 0 || txen_cnt != exp_txen
        || crc_run(obs_b, 8) !== 32'hDEBB20E3) begin
      tests_failed++;
      $display("FAIL reset_recover: got diffs %0d txen %0d expected 0 and %0d",
               byte_diffs(), txen_cnt, exp_txen);
    end
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    bit prev_en = 1'b0;
    int rises = 0;
    int cnt = 0;
    kick(3, 1'b0);
    prev_en = 1'b0;
    for (int c = 0; c < BOUND; c++) begin
      if (PhyTxEn && !prev_en) rises++;
      if (PhyTxEn) cnt++;
      prev_en = PhyTxEn;
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = (c == 20 || c == 150);
      @(negedge clk);
    end
    start = 1'b1;  // coincident with done: must be ignored
    tests_run++;
    if (!ok || rises != 1 || cnt != 4 * (54 + 3 + pad_of(3))) begin
      tests_failed++;
      $display("FAIL overlap_single: got done %0d rises %0d txen %0d expected 1, 1, %0d",
               ok, rises, cnt, 4 * (54 + 3 + pad_of(3)));
    end
    @(negedge clk);
    tests_run++;
    if ({busy, PhyTxEn} !== 2'b00) begin
      tests_failed++;
      $display("FAIL overlap_idle: got busy/en %b expected 00", {busy, PhyTxEn});
    end
    save_model();
    build_exp();
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if ({busy, PhyTxEn, PhyTxd} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL overlap_second_start: got busy/en/txd %b expected 1101", {busy, PhyTxEn, PhyTxd});
    end
    collect(ok);
    tests_run++;
    if (!ok || byte_diffs() != 0 || txen_cnt != exp_txen) begin
      tests_failed++;
      $display("FAIL overlap_second_frame: got diffs %0d txen %0d expected 0 and %0d",
               byte_diffs(), txen_cnt, exp_txen);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) pay_mem[i] = 8'($urandom());
    rand_inputs();
    test_reset();
    test_checksum();
    test_fcs();
    test_padding();
    test_handshake();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
